// File: rtl/bram_req_port.sv
// rtl/bram_req_port.sv - valid/ready request port driving a single-port synchronous block RAM
// Optional macro BRAM_REQ_PORT_OREG_EN selects a RAM with an extra output register (read latency 2).
module bram_req_port #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

`ifdef BRAM_REQ_PORT_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + LAT + 1);

  logic [LAT-1:0]        inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  issue;
  logic                  issue_rd;
  logic                  push;
  logic                  pop;
  logic                  rd_credit;

  always_comb begin
    outstanding = count;
    for (int i = 0; i < LAT; i++) begin
      outstanding = outstanding + CW'(inflight[i]);
    end
  end

  // A response leaving the FIFO this cycle frees its slot for a read issued this cycle.
  assign rsp_valid = ~rst & (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rd_credit = (outstanding - CW'(pop)) < CW'(RSP_DEPTH);
  assign req_ready = ~rst & (req_we | rd_credit);
  assign issue     = req_valid & req_ready;
  assign issue_rd  = issue & ~req_we;
  assign push      = inflight[LAT-1];

  assign mem_ce    = issue;
  assign mem_we    = issue & req_we;
  assign mem_addr  = issue ? req_addr : addr_q;
  assign mem_din   = issue ? req_wdata : din_q;
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      inflight[0] <= issue_rd;
      for (int i = 1; i < LAT; i++) begin
        inflight[i] <= inflight[i-1];
      end
      if (issue) begin
        addr_q <= req_addr;
        din_q  <= req_wdata;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_bram_req_port.sv
// tb/tb_bram_req_port.sv - randomized self-checking bench for bram_req_port
// Reads are modelled as a queue of expected data captured from a golden memory at acceptance.
module tb_bram_req_port;
  localparam int AW = 10;
  localparam int DW = 32;
`ifdef BRAM_REQ_PORT_OREG_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int n_checks = 0;
  int n_errors = 0;

  bram_req_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, optionally with an output register.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] dout_r = '0;
  logic [DW-1:0] dout_r2 = '0;
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      dout_r <= ram[mem_addr];
    end
    dout_r2 <= dout_r;
  end
`ifdef BRAM_REQ_PORT_OREG_EN
  assign mem_dout = dout_r2;
`else
  assign mem_dout = dout_r;
`endif

  logic [DW-1:0] gold [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  logic last_acc, last_rv, last_pop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    logic acc, pop;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    acc = req_valid & req_ready;
    pop = rsp_valid & rsp_ready;
    if (rst) begin
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_mem_ce", mem_ce, 0);
    end else begin
      if (v) check_eq("req_ready", req_ready, we ? 1 : ((exp_q.size() - int'(pop)) < DEPTH));
      check_eq("mem_ce", mem_ce, acc);
      if (acc) begin
        check_eq("mem_we", mem_we, we);
        check_eq("mem_addr", mem_addr, a);
        if (we) check_eq("mem_din", mem_din, d);
      end else begin
        check_eq("mem_we_idle", mem_we, 0);
      end
      if (rsp_valid) check_eq("rsp_pending", exp_q.size() != 0, 1);
      if (pop && exp_q.size() != 0) begin
        check_eq("rsp_rdata", rsp_rdata, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        if (we) gold[a] = d;
        else exp_q.push_back(gold[a]);
      end
      check_eq("no_overflow", exp_q.size() <= DEPTH, 1);
    end
    last_acc = acc; last_rv = rsp_valid; last_pop = pop;
    @(posedge clk);
    if (rst) exp_q.delete();
    #1;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, '0, '0, rr);
  endtask

  // Cycles from read acceptance until rsp_valid is first seen.
  task automatic measure_latency(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1);
      if (last_rv) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, acc_n, pops, tries;
  logic pv, pwe;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;

  initial begin
    for (int i = 0; i < (1 << AW); i++) gold[i] = '0;
    for (int i = 0; i < 3; i++) idle(1'b0);
    cycle(1'b1, 1'b0, 10'h001, '0, 1'b0);
    rst = 1'b0;
    idle(1'b0);
    check_eq("reset_mem_addr", mem_addr, 0);
    check_eq("reset_mem_din", mem_din, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);

    // Preload addresses 0..31 through the port.
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, AW'(i), DW'(i * 3), 1'b0);

    // Reset mid-read.
    cycle(1'b1, 1'b0, 10'h005, '0, 1'b1);
    check_eq("rmr_accept", last_acc, 1);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 10'h006, '0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      check_eq("rmr_no_rsp", last_rv, 0);
    end

    // Write then read the top address.
    cycle(1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF, 1'b1);
    cycle(1'b1, 1'b0, 10'h3FF, '0, 1'b1);
    check_eq("wr_rd_accept", last_acc, 1);
    measure_latency(lat);
    check_eq("wr_rd_latency", lat, LAT + 1);

    // Streaming 16 reads, one response per cycle.
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, AW'(i), '0, 1'b1);
      check_eq("stream_ready", last_acc, 1);
      pops += int'(last_pop);
    end
    for (int i = 0; i < LAT + 1; i++) begin
      idle(1'b1);
      pops += int'(last_pop);
    end
    check_eq("stream_pops", pops, 16);

    // Backpressure: only DEPTH reads fit, writes still pass.
    acc_n = 0;
    while (acc_n < DEPTH) begin
      cycle(1'b1, 1'b0, AW'(20 + acc_n), '0, 1'b0);
      if (last_acc) acc_n++;
      else break;
    end
    check_eq("bp_reads_accepted", acc_n, DEPTH);
    for (int i = 0; i < LAT + 1; i++) idle(1'b0);
    cycle(1'b1, 1'b1, 10'h040, 32'h1234_5678, 1'b0);
    check_eq("bp_write_accept", last_acc, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, AW'(20 + DEPTH), '0, 1'b0);
      check_eq("bp_read_blocked", last_acc, 0);
    end
    tries = 0;
    acc_n = 0;
    while (acc_n < 2 && tries < 20) begin
      cycle(1'b1, 1'b0, AW'(20 + DEPTH + acc_n), '0, 1'b1);
      if (last_acc) acc_n++;
      tries++;
    end
    check_eq("bp_remaining_accepted", acc_n, 2);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check_eq("bp_drained", exp_q.size(), 0);

    // Random mix with held requests and random backpressure.
    pv = 1'b0; pwe = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < 1000; i++) begin
      if (!pv && ($urandom_range(0, 9) < 7)) begin
        pv  = 1'b1;
        pwe = ($urandom_range(0, 2) == 0);
        pa  = AW'($urandom_range(0, 31));
        pd  = $urandom;
      end
      cycle(pv, pwe, pa, pd, $urandom_range(0, 3) != 0);
      if (last_acc) pv = 1'b0;
    end
    for (int i = 0; i < 20; i++) idle(1'b1);
    check_eq("random_drained", exp_q.size(), 0);

    // Latency of a fresh read at 0x010 with an empty FIFO.
    cycle(1'b1, 1'b0, 10'h010, '0, 1'b1);
    check_eq("lat_accept", last_acc, 1);
    measure_latency(lat);
    check_eq("read_latency", lat, LAT + 1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
